// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the regfile write arbiter
package regfile_pkg;
   localparam int N_BITS = 16;
   localparam int R_BITS = 3;
   localparam int N_REGS = 2 ** R_BITS;

   typedef struct packed {
      logic [R_BITS-1:0] addr;
      logic [N_BITS-1:0] data;
   } wb_req_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;
endpackage

// File: rtl/wb_holding_buffer.sv
// rtl/wb_holding_buffer.sv - one-entry writeback holding buffer with age bit
module wb_holding_buffer
   import regfile_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    in_tvalid,
   output logic    in_tready,
   input  wb_req_t in_tdata,
   input  logic    grant,
   input  logic    other_full,
   input  logic    other_grant,
   output logic    full,
   output wb_req_t req,
   output logic    age
);
   logic    full_d, full_q;
   logic    age_d, age_q;
   wb_req_t req_d, req_q;
   logic    accept;

   always_comb begin
      in_tready = !full_q || grant;
      accept    = in_tvalid && in_tready;
      full_d    = full_q;
      req_d     = req_q;
      age_d     = age_q;
      if (accept) begin
         full_d = 1'b1;
         req_d  = in_tdata;
         // The other entry only counts as older if it is still there after this edge.
         age_d  = other_full && !other_grant;
      end else if (grant) begin
         full_d = 1'b0;
         age_d  = 1'b0;
      end else if (other_grant) begin
         age_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         age_q  <= 1'b0;
         req_q  <= '0;
      end else begin
         full_q <= full_d;
         age_q  <= age_d;
         req_q  <= req_d;
      end
   end

   assign full = full_q;
   assign req  = req_q;
   assign age  = age_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between ALU and load writeback
// Two holding buffers feed an age-ordered arbiter and a registered write stage.
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [R_BITS-1:0] alu_addr,
   input  logic [N_BITS-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [R_BITS-1:0] mem_addr,
   input  logic [N_BITS-1:0] mem_data,
   output logic              regWrite,
   output logic [R_BITS-1:0] writeAddr3,
   output logic [N_BITS-1:0] writeData3,
   output logic [N_REGS-1:0] pending
);
   wb_req_t           alu_in, mem_in, alu_req, mem_req, win_req;
   logic              alu_full, mem_full, alu_age, mem_age;
   logic              alu_grant, mem_grant, grant_any;
   src_e              grant_src;
   logic              regwrite_d, regwrite_q;
   logic [R_BITS-1:0] waddr_d, waddr_q;
   logic [N_BITS-1:0] wdata_d, wdata_q;

   assign alu_in = {alu_addr, alu_data};
   assign mem_in = {mem_addr, mem_data};

   wb_holding_buffer u_alu_buf (
      .clock       (clock),
      .reset       (reset),
      .in_tvalid   (alu_valid),
      .in_tready   (alu_ready),
      .in_tdata    (alu_in),
      .grant       (alu_grant),
      .other_full  (mem_full),
      .other_grant (mem_grant),
      .full        (alu_full),
      .req         (alu_req),
      .age         (alu_age)
   );

   wb_holding_buffer u_mem_buf (
      .clock       (clock),
      .reset       (reset),
      .in_tvalid   (mem_valid),
      .in_tready   (mem_ready),
      .in_tdata    (mem_in),
      .grant       (mem_grant),
      .other_full  (alu_full),
      .other_grant (alu_grant),
      .full        (mem_full),
      .req         (mem_req),
      .age         (mem_age)
   );

   // Loads win ties: equal age means both arrived together and the load is earlier in program order.
   always_comb begin
      grant_any = alu_full || mem_full;
      grant_src = SRC_MEM;
      if (alu_full && !mem_full) begin
         grant_src = SRC_ALU;
      end else if (alu_full && mem_full && !alu_age && mem_age) begin
         grant_src = SRC_ALU;
      end
      alu_grant = grant_any && (grant_src == SRC_ALU);
      mem_grant = grant_any && (grant_src == SRC_MEM);
      win_req   = (grant_src == SRC_ALU) ? alu_req : mem_req;
   end

   always_comb begin
      regwrite_d = grant_any && (win_req.addr != '0);
      waddr_d    = grant_any ? win_req.addr : waddr_q;
      wdata_d    = grant_any ? win_req.data : wdata_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regwrite_q <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         regwrite_q <= regwrite_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign regWrite   = regwrite_q;
   assign writeAddr3 = waddr_q;
   assign writeData3 = wdata_q;

   always_comb begin
      pending = '0;
      for (int i = 1; i < N_REGS; i++) begin
         pending[i] = (alu_full && (alu_req.addr == R_BITS'(i)))
                   || (mem_full && (mem_req.addr == R_BITS'(i)))
                   || (regwrite_q && (waddr_q == R_BITS'(i)));
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, mem_valid, mem_ready, regWrite;
   logic [2:0]  alu_addr, mem_addr, writeAddr3;
   logic [15:0] alu_data, mem_data, writeData3;
   logic [7:0]  pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clock      (clk),
      .reset      (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .regWrite   (regWrite),
      .writeAddr3 (writeAddr3),
      .writeData3 (writeData3),
      .pending    (pending)
   );

   // Reference: each source holds at most one request stamped with its accept cycle; oldest stamp wins, MEM on a tie.
   logic        m_full [2];
   logic [2:0]  m_addr [2];
   logic [15:0] m_data [2];
   int          m_ts   [2];
   logic        m_rw;
   logic [2:0]  m_wa;
   logic [15:0] m_wd;
   int          cyc;
   logic [15:0] shadow [8];

   typedef struct {
      logic        av;
      logic [2:0]  aa;
      logic [15:0] ad;
      logic        mv;
      logic [2:0]  ma;
      logic [15:0] md;
      logic        ar;
      logic        mr;
      logic        rw;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [7:0]  pend;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int av, input int aa, input int ad, input int mv, input int ma,
                               input int md, input int ar, input int mr, input int rw, input int wa,
                               input int wd, input int pend);
      vec_t v;
      v.av = 1'(av);  v.aa = 3'(aa);  v.ad = 16'(ad);
      v.mv = 1'(mv);  v.ma = 3'(ma);  v.md = 16'(md);
      v.ar = 1'(ar);  v.mr = 1'(mr);  v.rw = 1'(rw);
      v.wa = 3'(wa);  v.wd = 16'(wd); v.pend = 8'(pend);
      return v;
   endfunction

   function automatic int m_grant();
      if (m_full[0] && m_full[1]) return (m_ts[0] < m_ts[1]) ? 0 : 1;
      if (m_full[0]) return 0;
      if (m_full[1]) return 1;
      return -1;
   endfunction

   function automatic logic m_ready(input int s);
      return !m_full[s] || (m_grant() == s);
   endfunction

   function automatic logic [7:0] m_pending();
      logic [7:0] p = '0;
      for (int i = 1; i < 8; i++) begin
         p[i] = (m_full[0] && m_addr[0] == 3'(i)) || (m_full[1] && m_addr[1] == 3'(i))
             || (m_rw && m_wa == 3'(i));
      end
      return p;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_full[s] = 1'b0; m_addr[s] = '0; m_data[s] = '0; m_ts[s] = 0;
      end
      m_rw = 1'b0; m_wa = '0; m_wd = '0;
   endtask

   task automatic cycle(input int av, input int aa, input int ad, input int mv, input int ma, input int md,
                        input bit use_model, output bit acc_a, output bit acc_m, output bit ar_s, output bit mr_s);
      int g;
      alu_valid = 1'(av); alu_addr = 3'(aa); alu_data = 16'(ad);
      mem_valid = 1'(mv); mem_addr = 3'(ma); mem_data = 16'(md);
      #1;
      ar_s  = alu_ready;
      mr_s  = mem_ready;
      g     = m_grant();
      acc_a = (av != 0) && m_ready(0);
      acc_m = (mv != 0) && m_ready(1);
      if (use_model) begin
         chk("alu_ready", 32'(alu_ready), 32'(m_ready(0)));
         chk("mem_ready", 32'(mem_ready), 32'(m_ready(1)));
      end
      @(posedge clk);
      if (g >= 0) begin
         m_rw = (m_addr[g] != 3'd0); m_wa = m_addr[g]; m_wd = m_data[g]; m_full[g] = 1'b0;
      end else begin
         m_rw = 1'b0;
      end
      if (acc_a) begin m_full[0] = 1'b1; m_addr[0] = 3'(aa); m_data[0] = 16'(ad); m_ts[0] = cyc; end
      if (acc_m) begin m_full[1] = 1'b1; m_addr[1] = 3'(ma); m_data[1] = 16'(md); m_ts[1] = cyc; end
      cyc++;
      #1;
      if (regWrite) shadow[writeAddr3] = writeData3;
      if (use_model) begin
         chk("regWrite", 32'(regWrite), 32'(m_rw));
         chk("writeAddr3", 32'(writeAddr3), 32'(m_wa));
         chk("writeData3", 32'(writeData3), 32'(m_wd));
         chk("pending", 32'(pending), 32'(m_pending()));
      end
   endtask

   bit          a, m, ar, mr;
   logic [18:0] wlog [$];
   logic [18:0] got, want;
   int          na, nm, gaps;
   bit          seen;

   initial begin
      cyc = 0;
      model_reset();
      for (int i = 0; i < 8; i++) shadow[i] = '0;
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      mem_valid = 0; mem_addr = 0; mem_data = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regWrite", 32'(regWrite), 0);
      chk("rst_writeAddr3", 32'(writeAddr3), 0);
      chk("rst_writeData3", 32'(writeData3), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_alu_ready", 32'(alu_ready), 1);
      chk("rst_mem_ready", 32'(mem_ready), 1);
      rst = 1'b0;

      // Directed table: single ALU write, same-cycle contention, MEM-before-ALU, address 0.
      tbl[0]  = mk(1, 3, 'h1234, 0, 0, 0,      1, 1, 0, 0, 'h0000, 'h08);
      tbl[1]  = mk(0, 0, 0,      0, 0, 0,      1, 1, 1, 3, 'h1234, 'h08);
      tbl[2]  = mk(0, 0, 0,      0, 0, 0,      1, 1, 0, 3, 'h1234, 'h00);
      tbl[3]  = mk(1, 2, 'hAAAA, 1, 2, 'h5555, 1, 1, 0, 3, 'h1234, 'h04);
      tbl[4]  = mk(0, 0, 0,      0, 0, 0,      0, 1, 1, 2, 'h5555, 'h04);
      tbl[5]  = mk(0, 0, 0,      0, 0, 0,      1, 1, 1, 2, 'hAAAA, 'h04);
      tbl[6]  = mk(0, 0, 0,      0, 0, 0,      1, 1, 0, 2, 'hAAAA, 'h00);
      tbl[7]  = mk(0, 0, 0,      1, 5, 'h0505, 1, 1, 0, 2, 'hAAAA, 'h20);
      tbl[8]  = mk(1, 6, 'h0606, 0, 0, 0,      1, 1, 1, 5, 'h0505, 'h60);
      tbl[9]  = mk(0, 0, 0,      0, 0, 0,      1, 1, 1, 6, 'h0606, 'h40);
      tbl[10] = mk(0, 0, 0,      0, 0, 0,      1, 1, 0, 6, 'h0606, 'h00);
      tbl[11] = mk(1, 0, 'hFFFF, 0, 0, 0,      1, 1, 0, 6, 'h0606, 'h00);
      tbl[12] = mk(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 'hFFFF, 'h00);
      tbl[13] = mk(0, 0, 0,      0, 0, 0,      1, 1, 0, 0, 'hFFFF, 'h00);
      for (int i = 0; i < 14; i++) begin
         cycle(int'(tbl[i].av), int'(tbl[i].aa), int'(tbl[i].ad), int'(tbl[i].mv), int'(tbl[i].ma),
               int'(tbl[i].md), 1'b0, a, m, ar, mr);
         chk($sformatf("tbl%0d_alu_ready", i), 32'(ar), 32'(tbl[i].ar));
         chk($sformatf("tbl%0d_mem_ready", i), 32'(mr), 32'(tbl[i].mr));
         chk($sformatf("tbl%0d_regWrite", i), 32'(regWrite), 32'(tbl[i].rw));
         chk($sformatf("tbl%0d_writeAddr3", i), 32'(writeAddr3), 32'(tbl[i].wa));
         chk($sformatf("tbl%0d_writeData3", i), 32'(writeData3), 32'(tbl[i].wd));
         chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
         if (i == 6) chk("final_reg2", 32'(shadow[2]), 32'h0000_AAAA);
      end

      // Reset with both buffers full: nothing buffered may ever be written.
      rst = 1'b1; model_reset(); @(posedge clk); #1; rst = 1'b0;
      cycle(1, 4, 'h4444, 1, 5, 'h5555, 1'b1, a, m, ar, mr);
      alu_valid = 0; mem_valid = 0;
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_regWrite", 32'(regWrite), 0);
      chk("midrst_pending", 32'(pending), 0);
      @(posedge clk); #1;
      chk("midrst_next_regWrite", 32'(regWrite), 0);
      chk("midrst_next_pending", 32'(pending), 0);
      chk("midrst_alu_ready", 32'(alu_ready), 1);
      chk("midrst_mem_ready", 32'(mem_ready), 1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 1'b1, a, m, ar, mr);
         chk("midrst_no_write", 32'(regWrite), 0);
      end

      // Both sources streaming: 8 requests each, grants must alternate MEM, ALU, MEM, ...
      na = 0; nm = 0; gaps = 0; seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
         cycle((na < 8) ? 1 : 0, 1, 'hA000 + na, (nm < 8) ? 1 : 0, 2, 'hB000 + nm, 1'b1, a, m, ar, mr);
         if (a) na++;
         if (m) nm++;
         if (regWrite) begin
            wlog.push_back({writeAddr3, writeData3});
            seen = 1'b1;
         end else if (seen && wlog.size() < 16) begin
            gaps++;
         end
      end
      chk("stream_write_count", 32'(wlog.size()), 16);
      chk("stream_gaps", 32'(gaps), 0);
      for (int k = 0; k < 16; k++) begin
         got  = (k < wlog.size()) ? wlog[k] : '1;
         want = (k % 2 == 0) ? {3'd2, 16'(32'hB000 + k / 2)} : {3'd1, 16'(32'hA000 + k / 2)};
         chk($sformatf("stream_write%0d", k), 32'(got), 32'(want));
      end

      // Random traffic against the reference model.
      rst = 1'b1; model_reset(); @(posedge clk); #1; rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         cycle(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)),
               ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)),
               1'b1, a, m, ar, mr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
